// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter sharing one asynchronous SRAM through a setup/strobe/hold access FSM.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] memAddr,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic              memRead,
  output logic              memWrite,
  output logic              memEable
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state;
  logic [3:0]        waitcnt;
  logic              iswrite;
  logic [DATA_W-1:0] wrdata;
  logic              drivebus;
  logic              pick1;

`ifdef MEM_ARB_RR_EN
  // lastgrant is 1 when port 1 owned the most recent access
  logic lastgrant;
  assign pick1 = req1 & (~req0 | ~lastgrant);
`else
  assign pick1 = req1 & ~req0;
`endif

  // Bus is released whenever the current access is not a write
  assign dataBus = drivebus ? wrdata : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      waitcnt  <= '0;
      iswrite  <= 1'b0;
      wrdata   <= '0;
      drivebus <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      grant    <= 2'b00;
      memAddr  <= '0;
      memRead  <= 1'b1;
      memWrite <= 1'b1;
      memEable <= 1'b1;
`ifdef MEM_ARB_RR_EN
      lastgrant <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state    <= SETUP;
            busy     <= 1'b1;
            grant    <= pick1 ? 2'b10 : 2'b01;
            iswrite  <= pick1 ? we1 : we0;
            drivebus <= pick1 ? we1 : we0;
            memAddr  <= pick1 ? addr1 : addr0;
            wrdata   <= pick1 ? wdata1 : wdata0;
            memEable <= 1'b0;
`ifdef MEM_ARB_RR_EN
            lastgrant <= pick1;
`endif
          end
        end
        SETUP: begin
          state    <= STROBE;
          waitcnt  <= 4'(WAIT_CYCLES - 1);
          memRead  <= iswrite;
          memWrite <= ~iswrite;
        end
        STROBE: begin
          // The edge that ends the strobe also samples read data and raises ack
          if (waitcnt == 4'd0) begin
            state    <= HOLD;
            memRead  <= 1'b1;
            memWrite <= 1'b1;
            ack0     <= grant[0];
            ack1     <= grant[1];
            if (!iswrite) begin
              rdata <= dataBus;
            end
          end else begin
            waitcnt <= waitcnt - 4'd1;
          end
        end
        HOLD: begin
          state    <= IDLE;
          busy     <= 1'b0;
          grant    <= 2'b00;
          memEable <= 1'b1;
          drivebus <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts every pin each cycle.
// Directed accesses pin latency, strobe width, arbitration order and mid-access reset.
module tb_mem_arbiter;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, busy, memRead, memWrite, memEable;
  logic [1:0]  grant;
  logic [15:0] rdata, memAddr;
  wire  [15:0] dataBus;

  logic        d3req;
  logic        d3ack0, d3ack1, d3busy, d3memRead, d3memWrite, d3memEable;
  logic [1:0]  d3grant;
  logic [15:0] d3rdata, d3memAddr;
  wire  [15:0] d3bus;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Transaction-level model of the access in flight
  logic        active;
  int          ph;
  int          own;
  logic        mw;
  logic [15:0] md, readVal, expRdata, expAddr;
`ifdef MEM_ARB_RR_EN
  logic        lastGrant;
`endif
  logic [15:0] sram [0:255];
  logic [15:0] mmem [0:255];

  logic        benchDriveEn;
  logic [15:0] benchDriveVal;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .grant(grant),
    .memAddr(memAddr), .dataBus(dataBus),
    .memRead(memRead), .memWrite(memWrite), .memEable(memEable)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0(d3req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(16'h0040), .addr1(16'h0000), .wdata0(16'h0000), .wdata1(16'h0000),
    .ack0(d3ack0), .ack1(d3ack1), .rdata(d3rdata), .busy(d3busy), .grant(d3grant),
    .memAddr(d3memAddr), .dataBus(d3bus),
    .memRead(d3memRead), .memWrite(d3memWrite), .memEable(d3memEable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM answers reads; otherwise the bench parks the bus at zero unless the DUT should be writing
  always_comb begin
    benchDriveEn  = 1'b0;
    benchDriveVal = 16'h0000;
    if (!memEable && !memRead) begin
      benchDriveEn  = 1'b1;
      benchDriveVal = sram[memAddr[7:0]];
    end else if (!rst || !(active && mw)) begin
      benchDriveEn = 1'b1;
    end
  end
  assign dataBus = benchDriveEn ? benchDriveVal : 16'hzzzz;

  assign d3bus = (!d3memEable && !d3memRead) ? 16'h1234 : 16'h0000;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int port, input logic w, input logic [15:0] a,
                               input logic [15:0] d, output int lat, output int strobes,
                               output logic [15:0] setupBus);
    int start;
    @(negedge clk);
    if (port == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    start    = cyc;
    lat      = -1;
    strobes  = 0;
    setupBus = 16'hxxxx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc == start + 1) setupBus = dataBus;
      if (!memRead || !memWrite) strobes++;
      if (port == 0 ? ack0 : ack1) begin
        lat = cyc - start;
        break;
      end
    end
    if (port == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  // Model update on each rising edge, pin comparison on each falling edge
  initial begin
    logic       readStrobe, writeStrobe;
    logic [1:0] expGrant;
    logic [15:0] expBus;
    for (int i = 0; i < 256; i++) begin
      sram[i] = 16'(i * 257) ^ 16'h5A5A;
      mmem[i] = sram[i];
    end
    active = 1'b0; ph = 0; own = 0; mw = 1'b0; md = 16'h0; readVal = 16'h0;
    expRdata = 16'h0; expAddr = 16'h0;
`ifdef MEM_ARB_RR_EN
    lastGrant = 1'b1;
`endif
    forever begin
      @(posedge clk);
      if (!memEable && !memWrite) sram[memAddr[7:0]] = dataBus;
      if (!rst) begin
        active = 1'b0; ph = 0; expRdata = 16'h0; expAddr = 16'h0;
`ifdef MEM_ARB_RR_EN
        lastGrant = 1'b1;
`endif
      end else if (active) begin
        if (ph == W + 2) active = 1'b0;
        else begin
          ph++;
          if (ph == W + 2 && !mw) expRdata = readVal;
        end
      end else if (req0 || req1) begin
`ifdef MEM_ARB_RR_EN
        own = (req0 && req1) ? (lastGrant ? 0 : 1) : (req0 ? 0 : 1);
        lastGrant = (own == 1);
`else
        own = req0 ? 0 : 1;
`endif
        mw      = (own == 1) ? we1 : we0;
        expAddr = (own == 1) ? addr1 : addr0;
        md      = (own == 1) ? wdata1 : wdata0;
        active  = 1'b1;
        ph      = 1;
        if (mw) mmem[expAddr[7:0]] = md;
        else readVal = mmem[expAddr[7:0]];
      end

      @(negedge clk);
      if (!rst) begin
        active = 1'b0; ph = 0; expRdata = 16'h0; expAddr = 16'h0;
`ifdef MEM_ARB_RR_EN
        lastGrant = 1'b1;
`endif
      end
      readStrobe  = active && !mw && ph >= 2 && ph <= W + 1;
      writeStrobe = active && mw && ph >= 2 && ph <= W + 1;
      expGrant    = active ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
      expBus      = (active && mw) ? md : (readStrobe ? readVal : 16'h0000);
      checkOutput("busy", 16'(busy), 16'(active));
      checkOutput("grant", 16'(grant), 16'(expGrant));
      checkOutput("ack0", 16'(ack0), 16'(active && ph == W + 2 && own == 0));
      checkOutput("ack1", 16'(ack1), 16'(active && ph == W + 2 && own == 1));
      checkOutput("memEable", 16'(memEable), 16'(!active));
      checkOutput("memRead", 16'(memRead), 16'(!readStrobe));
      checkOutput("memWrite", 16'(memWrite), 16'(!writeStrobe));
      checkOutput("memAddr", memAddr, expAddr);
      checkOutput("rdata", rdata, expRdata);
      checkOutput("dataBus", dataBus, expBus);
      checkOutput("strobeOverlap", 16'(memRead | memWrite), 16'd1);
    end
  end

  initial begin
    int lat, strb, n, start;
    logic [15:0] sb;
    int order [4];
    int expOrder [4];
`ifdef MEM_ARB_RR_EN
    expOrder = '{0, 1, 0, 1};
`else
    expOrder = '{0, 0, 0, 0};
`endif
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
    d3req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF, lat, strb, sb);
    checkOutput("t1Latency", 16'(lat), 16'd3);
    checkOutput("t1Strobes", 16'(strb), 16'd1);
    checkOutput("t1SetupBus", sb, 16'hBEEF);

    applyStimulus(1, 1'b0, 16'h0010, 16'h0000, lat, strb, sb);
    checkOutput("t2Latency", 16'(lat), 16'd3);
    checkOutput("t2Strobes", 16'(strb), 16'd1);
    checkOutput("t2SetupBus", sb, 16'h0000);
    checkOutput("t2Rdata", rdata, 16'hBEEF);

    // Both ports held high across four back-to-back accesses
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0030; addr1 = 16'h0031;
    order = '{9, 9, 9, 9};
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (ack0) begin order[n] = 0; n++; end
      else if (ack1) begin order[n] = 1; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t3Grant%0d", k), 16'(order[k]), 16'(expOrder[k]));

    // Three-cycle strobe instance
    @(negedge clk);
    d3req = 1'b1;
    start = cyc;
    lat = -1;
    strb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!d3memRead) strb++;
      if (d3ack0) begin
        lat = cyc - start;
        checkOutput("t4Busy", 16'(d3busy), 16'd1);
        checkOutput("t4Grant", 16'(d3grant), 16'd1);
        checkOutput("t4Addr", d3memAddr, 16'h0040);
        checkOutput("t4Write", 16'(d3memWrite), 16'd1);
        checkOutput("t4Ack1", 16'(d3ack1), 16'd0);
        break;
      end
    end
    d3req = 1'b0;
    checkOutput("t4Latency", 16'(lat), 16'd5);
    checkOutput("t4Strobes", 16'(strb), 16'd3);
    checkOutput("t4Rdata", d3rdata, 16'h1234);

    // Reset while a write strobe is low
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0012; wdata0 = 16'hA5A5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!memWrite) break;
    end
    checkOutput("t5InStrobe", 16'(memWrite), 16'd0);
    #1 rst = 1'b0;
    #1;
    checkOutput("t5Write", 16'(memWrite), 16'd1);
    checkOutput("t5Read", 16'(memRead), 16'd1);
    checkOutput("t5Enable", 16'(memEable), 16'd1);
    checkOutput("t5Bus", dataBus, 16'h0000);
    checkOutput("t5Ack", 16'(ack0), 16'd0);
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 1'b1, 16'h0011, 16'h1357, lat, strb, sb);
    checkOutput("t5PostLatency", 16'(lat), 16'd3);
    applyStimulus(1, 1'b0, 16'h0011, 16'h0000, lat, strb, sb);
    checkOutput("t5Readback", rdata, 16'h1357);

    // Free-running random traffic, including early req drops and field changes
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req0   = ($urandom_range(0, 3) != 0);
      req1   = ($urandom_range(0, 3) != 0);
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      addr0  = 16'h0020 + 16'($urandom_range(0, 7));
      addr1  = 16'h0020 + 16'($urandom_range(0, 7));
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
